// File: rtl/bcd_score_tracker.sv
// N-digit BCD game score with tick-gated increment, level stepping, wrap/saturate at max,
// a game-state FSM and a high-score register that survives new-game clears.
module bcd_score_tracker #(
    parameter int DIGITS     = 4,
    parameter int LEVEL_W    = 2,
    parameter int LEVEL_STEP = 40,
    parameter int WRAP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alive,
    input  logic                  tick,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   high_score,
    output logic [LEVEL_W-1:0]    level,
    output logic                  new_high,
    output logic                  wrapped,
    output logic [1:0]            state
);

    localparam int                 SW        = 4 * DIGITS;
    localparam logic [15:0]        STEP_LAST = 16'(LEVEL_STEP - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        score_q, score_d;
    logic [SW-1:0]        high_q, high_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [15:0]          step_q, step_d;
    logic                 new_high_q, new_high_d;
    logic                 wrapped_q, wrapped_d;
    logic                 inc, at_max, sat_block;

    // Ripple-carry decimal increment; all-9s naturally rolls over to all-0s.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] >= 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [SW-1:0] v);
        logic all;
        all = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] != 4'd9) all = 1'b0;
        end
        return all;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            level_q    <= '0;
            step_q     <= '0;
            new_high_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            level_q    <= level_d;
            step_q     <= step_d;
            new_high_q <= new_high_d;
            wrapped_q  <= wrapped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (alive)  state_d = ST_RUN;
                ST_RUN:  if (!alive) state_d = ST_OVER;
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        level_d    = level_q;
        step_d     = step_q;
        new_high_d = new_high_q;
        wrapped_d  = wrapped_q;

        inc       = (state_q == ST_RUN) && alive && tick && !clear;
        at_max    = all_nines(score_q);
        sat_block = (WRAP == 0) && at_max;

        if (clear) begin
            score_d    = '0;
            level_d    = '0;
            step_d     = '0;
            new_high_d = 1'b0;
            wrapped_d  = 1'b0;
        end else begin
            // In wrap mode the flag is a single-cycle pulse; in saturate mode it is sticky.
            if (WRAP != 0) wrapped_d = 1'b0;
            if (inc) begin
                if (at_max) wrapped_d = 1'b1;
                if (!sat_block) begin
                    score_d = bcd_inc(score_q);
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
                    end else begin
                        step_d = step_q + 16'd1;
                    end
                end
            end
            // Valid BCD compares correctly as plain unsigned binary, MSD first.
            if ((state_q == ST_RUN) && !alive) begin
                if (score_q > high_q) begin
                    high_d     = score_q;
                    new_high_d = 1'b1;
                end else begin
                    new_high_d = 1'b0;
                end
            end
        end
    end

    assign score      = score_q;
    assign high_score = high_q;
    assign level      = level_q;
    assign new_high   = new_high_q;
    assign wrapped    = wrapped_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Directed bench for bcd_score_tracker: a wrapping 4-digit instance and a saturating 2-digit one.
module tb_bcd_score_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alive, tick, clear;
    logic [15:0] score, high_score;
    logic [1:0]  level, state;
    logic        new_high, wrapped;

    logic        b_alive, b_tick, b_clear;
    logic [7:0]  b_score, b_high;
    logic [1:0]  b_level, b_state;
    logic        b_new_high, b_wrapped;

    int          errors = 0;
    int          checks = 0;
    int          a_cnt  = 0;
    int          a_inc  = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_score;

    always #5 clk = ~clk;

    bcd_score_tracker #(.DIGITS(4), .LEVEL_W(2), .LEVEL_STEP(40), .WRAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .alive(alive), .tick(tick), .clear(clear),
        .score(score), .high_score(high_score), .level(level),
        .new_high(new_high), .wrapped(wrapped), .state(state)
    );

    bcd_score_tracker #(.DIGITS(2), .LEVEL_W(2), .LEVEL_STEP(50), .WRAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .alive(b_alive), .tick(b_tick), .clear(b_clear),
        .score(b_score), .high_score(b_high), .level(b_level),
        .new_high(b_new_high), .wrapped(b_wrapped), .state(b_state)
    );

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          v;
        r = '0;
        v = n;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_level(input int events);
        return (events / 40 >= 3) ? 2'd3 : 2'(events / 40);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive n consecutive ticks; expected scores go through the scoreboard queue.
    task automatic a_ticks(input int n, input bit chk_each);
        for (int i = 0; i < n; i++) begin
            tick  = 1'b1;
            a_inc = a_inc + 1;
            a_cnt = (a_cnt + 1) % 10000;
            sb.push_back(to_bcd(a_cnt));
            cyc();
            exp_score = sb.pop_front();
            if (chk_each || i == n - 1) check("score", {16'd0, score}, {16'd0, exp_score});
        end
        tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; alive = 1'b0; tick = 1'b0; clear = 1'b0;
        b_alive = 1'b0; b_tick = 1'b0; b_clear = 1'b0;
        #1;
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_high", {16'd0, high_score}, 32'd0);
        check("rst_level", {30'd0, level}, 32'd0);
        check("rst_flags", {30'd0, new_high, wrapped}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        #21 rst_n = 1'b1;

        alive = 1'b1;
        cyc();
        check("run_entry", {30'd0, state}, 32'd1);
        check("run_entry_score", {16'd0, score}, 32'd0);
        a_ticks(9, 1'b1);
        a_ticks(1, 1'b1);
        check("state_run", {30'd0, state}, 32'd1);

        a_ticks(29, 1'b0);
        check("level39", {30'd0, level}, {30'd0, exp_level(a_inc)});
        a_ticks(1, 1'b1);
        check("level40", {30'd0, level}, 32'd1);
        a_ticks(79, 1'b0);
        check("level119", {30'd0, level}, 32'd2);
        a_ticks(1, 1'b1);
        check("level120", {30'd0, level}, 32'd3);
        a_ticks(80, 1'b0);
        check("level200", {30'd0, level}, 32'd3);
        a_ticks(199, 1'b0);
        a_ticks(1, 1'b1);

        a_ticks(9599, 1'b0);
        check("max_no_wrap", {31'd0, wrapped}, 32'd0);
        a_ticks(1, 1'b1);
        check("wrap_pulse", {31'd0, wrapped}, 32'd1);
        check("wrap_level", {30'd0, level}, {30'd0, exp_level(a_inc)});
        cyc();
        check("wrap_pulse_end", {31'd0, wrapped}, 32'd0);
        check("wrap_hold", {16'd0, score}, 32'd0);

        a_ticks(3, 1'b1);
        tick = 1'b1; clear = 1'b1;
        cyc();
        tick = 1'b0; clear = 1'b0;
        a_cnt = 0; a_inc = 0; sb.delete();
        check("clr_tick_score", {16'd0, score}, 32'd0);
        check("clr_tick_state", {30'd0, state}, 32'd0);
        check("clr_tick_level", {30'd0, level}, 32'd0);
        cyc();
        check("rerun", {30'd0, state}, 32'd1);

        a_ticks(57, 1'b0);
        alive = 1'b0;
        cyc();
        check("g1_state", {30'd0, state}, 32'd2);
        check("g1_high", {16'd0, high_score}, 32'h57);
        check("g1_new_high", {31'd0, new_high}, 32'd1);
        check("g1_score", {16'd0, score}, 32'h57);
        tick = 1'b1; alive = 1'b1;
        cyc();
        cyc();
        tick = 1'b0; alive = 1'b0;
        check("over_tick_score", {16'd0, score}, 32'h57);
        check("over_alive_state", {30'd0, state}, 32'd2);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        a_cnt = 0; a_inc = 0;
        check("g1_clr_score", {16'd0, score}, 32'd0);
        check("g1_clr_high", {16'd0, high_score}, 32'h57);
        check("g1_clr_nh", {31'd0, new_high}, 32'd0);
        check("g1_clr_state", {30'd0, state}, 32'd0);

        alive = 1'b1;
        cyc();
        a_ticks(42, 1'b0);
        alive = 1'b0;
        cyc();
        check("g2_state", {30'd0, state}, 32'd2);
        check("g2_high", {16'd0, high_score}, 32'h57);
        check("g2_new_high", {31'd0, new_high}, 32'd0);

        clear = 1'b1;
        cyc();
        clear = 1'b0; alive = 1'b1;
        a_cnt = 0; a_inc = 0;
        cyc();
        a_ticks(5, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_score", {16'd0, score}, 32'd0);
        check("arst_high", {16'd0, high_score}, 32'd0);
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_flags", {28'd0, level, new_high, wrapped}, 32'd0);
        alive = 1'b0;
        #2 rst_n = 1'b1;
        cyc();

        b_alive = 1'b1;
        cyc();
        check("b_run", {30'd0, b_state}, 32'd1);
        b_tick = 1'b1;
        for (int i = 0; i < 99; i++) cyc();
        b_tick = 1'b0;
        check("b_max", {24'd0, b_score}, 32'h99);
        check("b_max_level", {30'd0, b_level}, 32'd1);
        check("b_max_flag", {31'd0, b_wrapped}, 32'd0);
        b_tick = 1'b1;
        cyc();
        check("b_sat_score", {24'd0, b_score}, 32'h99);
        check("b_sat_flag", {31'd0, b_wrapped}, 32'd1);
        check("b_sat_level", {30'd0, b_level}, 32'd1);
        cyc(); cyc(); cyc();
        check("b_sticky_score", {24'd0, b_score}, 32'h99);
        check("b_sticky_flag", {31'd0, b_wrapped}, 32'd1);
        check("b_frozen_level", {30'd0, b_level}, 32'd1);
        b_tick = 1'b0; b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        check("b_clr_flag", {31'd0, b_wrapped}, 32'd0);
        check("b_clr_score", {24'd0, b_score}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
